// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - MD5 constants, round tables, byte swap and channel FSM state type
package md5_pkg;

    localparam int NUM_WORDS = 16;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    localparam logic [31:0] K_TAB [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } md5_state_t;

    function automatic logic [31:0] k_of(input logic [5:0] i);
        return K_TAB[i];
    endfunction

    // Shift amount repeats every four steps within each 16-step round
    function automatic logic [4:0] shift_of(input logic [5:0] i);
        logic [4:0] s;
        case ({i[5:4], i[1:0]})
            4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
            4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
            4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
            4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  default: s = 5'd21;
        endcase
        return s;
    endfunction

    // Shift is never zero, so the right shift by 32-s stays in range
    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/md5_chan_core.sv
// rtl/md5_chan_core.sv - one MD5 channel: message buffer, FSM, round datapath, chain state (MD5_CHAIN_EN adds cont)
module md5_chan_core
    import md5_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         start,
`ifdef MD5_CHAIN_EN
    input  logic         cont,
`endif
    input  logic         wr_en,
    input  logic [3:0]   wr_idx,
    input  logic [31:0]  wr_data,
    output logic         busy,
    output logic         done,
    output logic         wr_drop,
    output logic [127:0] chain
);

    md5_state_t  state_q, state_d;
    logic [31:0] buf_q [NUM_WORDS];
    logic [31:0] a_q, b_q, c_q, d_q;
    logic [31:0] ha_q, hb_q, hc_q, hd_q;
    logic [5:0]  rnd_q;
    logic        start_ok;
    logic        use_chain;
    logic [31:0] f;
    logic [3:0]  g;
    logic [31:0] sum;
    logic [31:0] b_new;

    assign busy     = (state_q == ST_ROUND) || (state_q == ST_FINAL);
    assign done     = (state_q == ST_DONE);
    assign start_ok = start && !busy && !clear;
    assign wr_drop  = wr_en && busy && !clear;
    assign chain    = {ha_q, hb_q, hc_q, hd_q};

`ifdef MD5_CHAIN_EN
    assign use_chain = cont;
`else
    assign use_chain = 1'b0;
`endif

    // Message buffer: written only while the channel is not compressing
    always_ff @(posedge clk) begin
        if (wr_en && !busy && !clear) begin
            buf_q[wr_idx] <= wr_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; clear overrides everything
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start) state_d = ST_ROUND;
                ST_ROUND:         if (rnd_q == 6'd63) state_d = ST_FINAL;
                ST_FINAL:         state_d = ST_DONE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // Round function and message word selection for the current step
    always_comb begin
        f = '0;
        g = '0;
        case (rnd_q[5:4])
            2'd0: begin
                f = (b_q & c_q) | (~b_q & d_q);
                g = rnd_q[3:0];
            end
            2'd1: begin
                f = (d_q & b_q) | (~d_q & c_q);
                g = rnd_q[3:0] * 4'd5 + 4'd1;
            end
            2'd2: begin
                f = b_q ^ c_q ^ d_q;
                g = rnd_q[3:0] * 4'd3 + 4'd5;
            end
            default: begin
                f = c_q ^ (b_q | ~d_q);
                g = rnd_q[3:0] * 4'd7;
            end
        endcase
        sum   = a_q + f + k_of(rnd_q) + buf_q[g];
        b_new = b_q + rotl(sum, shift_of(rnd_q));
    end

    // Working registers, round counter and chain state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            rnd_q <= '0;
            ha_q  <= IV_A;
            hb_q  <= IV_B;
            hc_q  <= IV_C;
            hd_q  <= IV_D;
        end else if (clear) begin
            rnd_q <= '0;
            ha_q  <= IV_A;
            hb_q  <= IV_B;
            hc_q  <= IV_C;
            hd_q  <= IV_D;
        end else if (start_ok) begin
            rnd_q <= '0;
            if (use_chain) begin
                a_q <= ha_q;
                b_q <= hb_q;
                c_q <= hc_q;
                d_q <= hd_q;
            end else begin
                a_q  <= IV_A;
                b_q  <= IV_B;
                c_q  <= IV_C;
                d_q  <= IV_D;
                ha_q <= IV_A;
                hb_q <= IV_B;
                hc_q <= IV_C;
                hd_q <= IV_D;
            end
        end else if (state_q == ST_ROUND) begin
            a_q   <= d_q;
            b_q   <= b_new;
            c_q   <= b_q;
            d_q   <= c_q;
            rnd_q <= rnd_q + 6'd1;
        end else if (state_q == ST_FINAL) begin
            ha_q <= ha_q + a_q;
            hb_q <= hb_q + b_q;
            hc_q <= hc_q + c_q;
            hd_q <= hd_q + d_q;
        end
    end

endmodule

// File: rtl/md5_multi_unit.sv
// rtl/md5_multi_unit.sv - NUM_CH-channel MD5 block engine with shared write port and digest mux (MD5_CHAIN_EN adds cont)
module md5_multi_unit
    import md5_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] clear,
    input  logic [NUM_CH-1:0] start,
`ifdef MD5_CHAIN_EN
    input  logic [NUM_CH-1:0] cont,
`endif
    input  logic              write,
    input  logic [CH_W+3:0]   writeaddr,
    input  logic [31:0]       writedata,
    input  logic [CH_W-1:0]   digest_sel,
    output logic [127:0]      digest,
    output logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] busy,
    output logic              wr_err
);

    logic [CH_W-1:0]   wr_ch;
    logic              wr_oor;
    logic [NUM_CH-1:0] wr_drop;
    logic [127:0]      chain [NUM_CH];

    assign wr_ch  = writeaddr[CH_W+3:4];
    assign wr_oor = ({1'b0, wr_ch} >= (CH_W+1)'(NUM_CH));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        md5_chan_core u_core (
            .clk     (clk),
            .rst_n   (reset_n),
            .clear   (clear[c]),
            .start   (start[c]),
`ifdef MD5_CHAIN_EN
            .cont    (cont[c]),
`endif
            .wr_en   (write && (wr_ch == CH_W'(c))),
            .wr_idx  (writeaddr[3:0]),
            .wr_data (writedata),
            .busy    (busy[c]),
            .done    (done[c]),
            .wr_drop (wr_drop[c]),
            .chain   (chain[c])
        );
    end

    // Dropped writes (busy channel or nonexistent channel) flag one cycle later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= write && (wr_oor || (|wr_drop));
        end
    end

    // Digest mux with per-word byte swap; unselected/nonexistent channel reads zero
    always_comb begin
        digest = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (digest_sel == CH_W'(c)) begin
                digest = {bswap(chain[c][127:96]), bswap(chain[c][95:64]),
                          bswap(chain[c][63:32]),  bswap(chain[c][31:0])};
            end
        end
    end

endmodule

// File: tb/tb_md5_multi_unit.sv
// tb/tb_md5_multi_unit.sv - scoreboard bench for md5_multi_unit
module tb_md5_multi_unit;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    localparam logic [127:0] DG_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] DG_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] DG_IV    = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] DG_A64   = 128'h014842d480b571495a4a0363793f7367;

    logic              clk;
    logic              reset_n;
    logic [NUM_CH-1:0] clear;
    logic [NUM_CH-1:0] start;
`ifdef MD5_CHAIN_EN
    logic [NUM_CH-1:0] cont;
`endif
    logic              write;
    logic [CH_W+3:0]   writeaddr;
    logic [31:0]       writedata;
    logic [CH_W-1:0]   digest_sel;
    logic [127:0]      digest;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] busy;
    logic              wr_err;

    typedef struct {
        int           ch;
        logic [127:0] dig;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   t0       = 0;

    md5_multi_unit #(.NUM_CH(NUM_CH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .start      (start),
`ifdef MD5_CHAIN_EN
        .cont       (cont),
`endif
        .write      (write),
        .writeaddr  (writeaddr),
        .writedata  (writedata),
        .digest_sel (digest_sel),
        .digest     (digest),
        .done       (done),
        .busy       (busy),
        .wr_err     (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input int ch, input int idx, input logic [31:0] data);
        write     = 1'b1;
        writeaddr = {CH_W'(ch), 4'(idx)};
        writedata = data;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic load_block(input int ch, input logic [31:0] w [16]);
        for (int i = 0; i < 16; i++) write_word(ch, i, w[i]);
    endtask

    task automatic pulse_start(input logic [NUM_CH-1:0] mask);
        start = mask;
        @(negedge clk);
        start = '0;
        t0    = cyc;
    endtask

    // Wait for every channel in mask, check latency, then drain the scoreboard
    task automatic wait_done(input string tag, input logic [NUM_CH-1:0] mask);
        while (((done & mask) != mask) && (cyc - t0 < 200)) @(negedge clk);
        check({tag, "_latency"}, 128'(cyc - t0), 128'(65));
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            digest_sel = CH_W'(e.ch);
            #1;
            check({tag, "_digest"}, digest, e.dig);
        end
    endtask

    logic [31:0] blk_empty [16];
    logic [31:0] blk_abc   [16];
    logic [31:0] blk_a64   [16];
    logic [31:0] blk_pad   [16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            blk_empty[i] = '0;
            blk_abc[i]   = '0;
            blk_a64[i]   = 32'h61616161;
            blk_pad[i]   = '0;
        end
        blk_empty[0] = 32'h00000080;
        blk_abc[0]   = 32'h80636261;
        blk_abc[14]  = 32'h00000018;
        blk_pad[0]   = 32'h00000080;
        blk_pad[14]  = 32'h00000200;

        reset_n    = 1'b0;
        clear      = '0;
        start      = '0;
`ifdef MD5_CHAIN_EN
        cont       = '0;
`endif
        write      = 1'b0;
        writeaddr  = '0;
        writedata  = '0;
        digest_sel = '0;
        repeat (3) @(negedge clk);
        check("rst_done", 128'(done), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_wr_err", 128'(wr_err), 128'(0));
        check("rst_iv_digest", digest, DG_IV);
        reset_n = 1'b1;
        @(negedge clk);

        // "abc" on channel 2; others stay not done
        load_block(2, blk_abc);
        sb.push_back('{ch: 2, dig: DG_ABC});
        pulse_start(4'b0100);
        check("abc_busy", 128'(busy), 128'(4'b0100));
        wait_done("abc", 4'b0100);
        check("abc_done_mask", 128'(done), 128'(4'b0100));

        // Empty string on channel 0
        load_block(0, blk_empty);
        sb.push_back('{ch: 0, dig: DG_EMPTY});
        pulse_start(4'b0001);
        wait_done("empty", 4'b0001);

        // Concurrency: ch1 "abc", ch3 empty with M0 written in the start cycle
        load_block(1, blk_abc);
        load_block(3, blk_empty);
        write_word(3, 0, 32'hdeadbeef);
        sb.push_back('{ch: 1, dig: DG_ABC});
        sb.push_back('{ch: 3, dig: DG_EMPTY});
        write     = 1'b1;
        writeaddr = {CH_W'(3), 4'd0};
        writedata = 32'h00000080;
        pulse_start(4'b1010);
        write = 1'b0;
        wait_done("conc", 4'b1010);

        // Write to an idle/done channel is stored without error
        write_word(0, 0, 32'h00000080);
        check("done_write_no_err", 128'(wr_err), 128'(0));

        // Write to busy ch1 is dropped and flagged; restart mid-round ignored
        sb.push_back('{ch: 1, dig: DG_ABC});
        pulse_start(4'b0010);
        repeat (10) @(negedge clk);
        write_word(1, 0, 32'hffffffff);
        check("busy_wr_err_pulse", 128'(wr_err), 128'(1));
        @(negedge clk);
        check("busy_wr_err_clear", 128'(wr_err), 128'(0));
        start = 4'b0010;
        @(negedge clk);
        start = '0;
        wait_done("busywr", 4'b0010);
        sb.push_back('{ch: 1, dig: DG_ABC});
        pulse_start(4'b0010);
        wait_done("rerun", 4'b0010);

        // Clear ch0 around round 30, then a fresh run
        pulse_start(4'b0001);
        repeat (29) @(negedge clk);
        check("clr_busy_before", 128'(busy[0]), 128'(1));
        clear = 4'b0001;
        @(negedge clk);
        clear = '0;
        check("clr_busy", 128'(busy[0]), 128'(0));
        check("clr_done", 128'(done[0]), 128'(0));
        digest_sel = 2'd0;
        #1;
        check("clr_iv", digest, DG_IV);
        @(negedge clk);
        sb.push_back('{ch: 0, dig: DG_EMPTY});
        pulse_start(4'b0001);
        wait_done("clr_rerun", 4'b0001);

`ifdef MD5_CHAIN_EN
        // Two-block message on ch2: "a"x64 then padding block chained
        load_block(2, blk_a64);
        cont = 4'b0000;
        pulse_start(4'b0100);
        while (!done[2] && (cyc - t0 < 200)) @(negedge clk);
        check("chain_blk1_latency", 128'(cyc - t0), 128'(65));
        load_block(2, blk_pad);
        sb.push_back('{ch: 2, dig: DG_A64});
        cont = 4'b0100;
        pulse_start(4'b0100);
        cont = '0;
        wait_done("chain", 4'b0100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
